// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD serializer arbiter.
package lcd_pkg;

  localparam logic LCD_CMD  = 1'b0;
  localparam logic LCD_DATA = 1'b1;

  typedef logic [7:0] lcd_byte_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_XFER  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module lcd_rr_pick #(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  // scan from the pointer position, first hit wins
  always_comb begin
    logic [PTR_W-1:0] j;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!valid && req[j]) begin
        valid     = 1'b1;
        onehot[j] = 1'b1;
        idx       = j;
      end
    end
  end

endmodule

// File: rtl/lcd_spi_arbiter.sv
// Burst-granular round-robin arbiter in front of the single LCD byte serializer.
// A requester keeps the grant until its req_last byte is accepted; a one-entry
// holding register feeds the serializer at up to one byte per cycle.
// Optional stall timeout: define LCD_ARB_TIMEOUT_EN to abort a burst whose owner
// stops presenting bytes for TIMEOUT_CYC cycles.
//
// state | meaning
// IDLE  | no owner, arbitrate among req
// XFER  | owner granted, bytes flow through holding register
// DRAIN | grant released, waiting for the held byte to reach the serializer
module lcd_spi_arbiter
  import lcd_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_byte,
  input  logic [N_REQ-1:0]   req_dc,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   gnt,
  output logic               ser_valid,
  output logic [7:0]         ser_byte,
  output logic               ser_dc,
  input  logic               ser_ready,
  output logic               arb_busy,
  output logic               timeout_evt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             hold_vld_q, hold_vld_d;
  lcd_byte_t        hold_byte_q, hold_byte_d;
  logic             hold_dc_q, hold_dc_d;

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             tout_q, tout_d;
`endif

  logic [N_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;
  logic             can_load;
  logic             accept;
  logic [PTR_W-1:0] ptr_after_owner;

  lcd_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // holding register can take a byte when empty or when it drains this same cycle
  assign can_load        = !hold_vld_q || ser_ready;
  assign req_ready       = gnt_q & req & {N_REQ{can_load}};
  assign accept          = |req_ready;
  assign ptr_after_owner = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  assign gnt       = gnt_q;
  assign ser_valid = hold_vld_q;
  assign ser_byte  = hold_byte_q;
  assign ser_dc    = hold_dc_q;
  assign arb_busy  = (state_q != ARB_IDLE) || hold_vld_q;
`ifdef LCD_ARB_TIMEOUT_EN
  assign timeout_evt = tout_q;
`else
  assign timeout_evt = 1'b0;
`endif

  // next-state, grant, pointer and holding-register logic
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    hold_vld_d  = hold_vld_q;
    hold_byte_d = hold_byte_q;
    hold_dc_d   = hold_dc_q;
`ifdef LCD_ARB_TIMEOUT_EN
    stall_d = stall_q;
    tout_d  = 1'b0;
`endif

    if (accept) begin
      hold_vld_d  = 1'b1;
      hold_byte_d = req_byte[{owner_q, 3'b000} +: 8];
      hold_dc_d   = req_dc[owner_q];
    end else if (ser_ready) begin
      hold_vld_d = 1'b0;
    end

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_onehot;
          owner_d = pick_idx;
          state_d = ARB_XFER;
`ifdef LCD_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end
      ARB_XFER: begin
        if (accept) begin
`ifdef LCD_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
          if (req_last[owner_q]) begin
            gnt_d   = '0;
            ptr_d   = ptr_after_owner;
            state_d = ARB_DRAIN;
          end
        end
`ifdef LCD_ARB_TIMEOUT_EN
        else if (stall_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          gnt_d   = '0;
          ptr_d   = ptr_after_owner;
          tout_d  = 1'b1;
          stall_d = '0;
          state_d = ARB_DRAIN;
        end else begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
      ARB_DRAIN: begin
        if (!hold_vld_q) state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // state register with synchronous active-low reset; a held byte is discarded
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      hold_vld_q  <= 1'b0;
      hold_byte_q <= '0;
      hold_dc_q   <= LCD_CMD;
`ifdef LCD_ARB_TIMEOUT_EN
      stall_q     <= '0;
      tout_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      hold_vld_q  <= hold_vld_d;
      hold_byte_q <= hold_byte_d;
      hold_dc_q   <= hold_dc_d;
`ifdef LCD_ARB_TIMEOUT_EN
      stall_q     <= stall_d;
      tout_q      <= tout_d;
`endif
    end
  end

endmodule
